// File: rtl/map_tile_renderer_if.sv
// Pixel request/response bundle for the maze-tile renderer.
// The master drives the pixel request and frame controls; the slave returns the coloured pixel.
interface map_tile_renderer_if #(
    parameter int TILE    = 8,
    parameter int COLOR_W = 4
);
    localparam int CW = $clog2(TILE);

    logic               frame_start;
    logic               flash_en;
    logic               in_valid;
    logic [CW-1:0]      sx;
    logic [CW-1:0]      sy;
    logic [3:0]         sprite_code;
    logic               out_valid;
    logic [COLOR_W-1:0] R;
    logic [COLOR_W-1:0] G;
    logic [COLOR_W-1:0] B;

    modport master (
        output frame_start, flash_en, in_valid, sx, sy, sprite_code,
        input  out_valid, R, G, B
    );

    modport slave (
        input  frame_start, flash_en, in_valid, sx, sy, sprite_code,
        output out_valid, R, G, B
    );
endinterface

// File: rtl/map_tile_renderer.sv
// Two-stage maze-tile pixel generator: S1 classifies the tile geometry, S2 picks the colour.
// Power pellets blink on a frame counter; walls flash blue/white while flash_en is held.
module map_tile_renderer #(
    parameter int          TILE         = 8,
    parameter int          COLOR_W      = 4,
    parameter int          BLINK_FRAMES = 15,
    parameter int          FLASH_FRAMES = 12,
    parameter logic [11:0] PELLET_RGB   = 12'hFB9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    map_tile_renderer_if.slave   bus
);
    localparam int CW = $clog2(TILE);
    localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam int FW = (FLASH_FRAMES > 2) ? $clog2(FLASH_FRAMES) : 1;
    localparam int PW = 3 * COLOR_W;

    localparam logic [CW-1:0] L_C   = CW'(TILE / 2 - 1);
    localparam logic [CW-1:0] LP1_C = CW'(TILE / 2);
    localparam logic [CW-1:0] LM1_C = CW'(TILE / 2 - 2);
    localparam logic [CW-1:0] H_C   = CW'(TILE / 2 + 1);
    localparam logic [CW-1:0] HP1_C = CW'(TILE / 2 + 2);
    localparam logic [CW-1:0] QLO_C = CW'(TILE / 4);
    localparam logic [CW-1:0] QHI_C = CW'(3 * TILE / 4 - 1);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [CW-1:0] TM2_C = CW'(TILE - 2);

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

    // A nibble widens by repeating itself from the MSB down, so F stays full scale.
    function automatic logic [COLOR_W-1:0] scale_nibble(input logic [3:0] n);
        localparam int NREP = (COLOR_W + 3) / 4;
        logic [4*NREP-1:0] rep;
        rep = {NREP{n}};
        return rep[4*NREP-1 -: COLOR_W];
    endfunction

    localparam logic [COLOR_W-1:0] CMAX = '1;
    localparam logic [PW-1:0] WALL_BLUE  = {{(2*COLOR_W){1'b0}}, CMAX};
    localparam logic [PW-1:0] WALL_WHITE = {CMAX, CMAX, CMAX};
    localparam logic [PW-1:0] PELLET     = {scale_nibble(PELLET_RGB[11:8]),
                                            scale_nibble(PELLET_RGB[7:4]),
                                            scale_nibble(PELLET_RGB[3:0])};

    logic          v1_d, v1_q, hit1_d, hit1_q, blink1_d, blink1_q, white1_d, white1_q;
    logic [3:0]    code1_d, code1_q;
    logic          out_valid_d, out_valid_q;
    logic [PW-1:0] rgb_d, rgb_q;
    logic [BW-1:0] blink_cnt_d, blink_cnt_q;
    logic [FW-1:0] flash_cnt_d, flash_cnt_q;
    logic          blink_on_d, blink_on_q, flash_white_d, flash_white_q;

    logic [CW-1:0] x, y;
    assign x = bus.sx;
    assign y = bus.sy;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hit1_d = 1'b0;
        case (bus.sprite_code)
            4'd1:  hit1_d = (y == H_C);
            4'd2:  hit1_d = (x == L_C);
            4'd3:  hit1_d = (y == L_C);
            4'd4:  hit1_d = (x == H_C);
            4'd5:  hit1_d = (y == H_C && x > HP1_C) || (x == H_C && y > HP1_C)
                            || (x == HP1_C && y == HP1_C);
            4'd6:  hit1_d = (y == H_C && x < LM1_C) || (x == L_C && y > HP1_C)
                            || (x == LM1_C && y == HP1_C);
            4'd7:  hit1_d = (y == L_C && x < LM1_C) || (x == L_C && y < LM1_C)
                            || (x == LM1_C && y == LM1_C);
            4'd0:  hit1_d = (y == L_C && x > HP1_C) || (x == H_C && y < LM1_C)
                            || (x == HP1_C && y == LM1_C);
            4'd9:  hit1_d = (x == L_C || x == LP1_C) && (y == L_C || y == LP1_C);
            4'd10: hit1_d = (x >= QLO_C && x <= QHI_C && y >= ONE_C && y <= TM2_C)
                            || (y >= QLO_C && y <= QHI_C && x >= ONE_C && x <= TM2_C);
            default: hit1_d = 1'b0;
        endcase
        v1_d     = bus.in_valid;
        code1_d  = bus.sprite_code;
        blink1_d = blink_on_q;
        white1_d = flash_white_q;
    end

    // Only codes 0-7, 9 and 10 can carry a hit, so anything past a wall is a pellet of some kind.
    always_comb begin
        rgb_d       = '0;
        out_valid_d = v1_q;
        if (v1_q && hit1_q) begin
            if (code1_q <= 4'd7)                  rgb_d = white1_q ? WALL_WHITE : WALL_BLUE;
            else if (code1_q == 4'd9 || blink1_q) rgb_d = PELLET;
        end
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_on_d    = blink_on_q;
        flash_cnt_d   = flash_cnt_q;
        flash_white_d = flash_white_q;
        if (bus.frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
        // Dropping flash_en beats a coincident frame_start.
        if (!bus.flash_en) begin
            flash_cnt_d   = '0;
            flash_white_d = 1'b0;
        end else if (bus.frame_start) begin
            if (flash_cnt_q == FLASH_LAST) begin
                flash_cnt_d   = '0;
                flash_white_d = ~flash_white_q;
            end else begin
                flash_cnt_d = flash_cnt_q + FW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q          <= 1'b0;
            hit1_q        <= 1'b0;
            blink1_q      <= 1'b0;
            white1_q      <= 1'b0;
            code1_q       <= '0;
            out_valid_q   <= 1'b0;
            rgb_q         <= '0;
            blink_cnt_q   <= '0;
            flash_cnt_q   <= '0;
            blink_on_q    <= 1'b1;
            flash_white_q <= 1'b0;
        end else begin
            v1_q          <= v1_d;
            hit1_q        <= hit1_d;
            blink1_q      <= blink1_d;
            white1_q      <= white1_d;
            code1_q       <= code1_d;
            out_valid_q   <= out_valid_d;
            rgb_q         <= rgb_d;
            blink_cnt_q   <= blink_cnt_d;
            flash_cnt_q   <= flash_cnt_d;
            blink_on_q    <= blink_on_d;
            flash_white_q <= flash_white_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.R         = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign bus.G         = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.B         = rgb_q[COLOR_W-1:0];
endmodule

// File: tb/tb_map_tile_renderer.sv
// Bench for map_tile_renderer: DUT A (T=8, 4-bit, blink 2, flash 1), DUT B (T=16, 6-bit, defaults).
// Both run every cycle against a frame-counting reference model; directed tables cover hand-derived pixels.
module tb_map_tile_renderer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    map_tile_renderer_if #(.TILE(8),  .COLOR_W(4)) if_a ();
    map_tile_renderer_if #(.TILE(16), .COLOR_W(6)) if_b ();

    map_tile_renderer #(.TILE(8), .COLOR_W(4), .BLINK_FRAMES(2), .FLASH_FRAMES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    map_tile_renderer #(.TILE(16), .COLOR_W(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));

    int checks = 0;
    int errors = 0;

    // Reference-model state: frames seen since reset / since flash enable.
    int tile_n[2]  = '{8, 16};
    int width_n[2] = '{4, 6};
    int blink_n[2] = '{2, 15};
    int flash_n[2] = '{1, 12};
    int blink_pulses[2];
    int flash_pulses[2];
    int exp_out[2];
    bit fe_hold[2];

    typedef struct {
        int code;
        int x;
        int y;
        int rgb;
    } vec_t;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pack(int v, int r, int g, int b, int w);
        return (v << 24) | (r << (2 * w)) | (g << w) | b;
    endfunction

    function automatic int out_of(int k);
        if (k == 0) return pack(int'(if_a.out_valid), int'(if_a.R), int'(if_a.G), int'(if_a.B), 4);
        return pack(int'(if_b.out_valid), int'(if_b.R), int'(if_b.G), int'(if_b.B), 6);
    endfunction

    function automatic bit geom(int t, int code, int x, int y);
        int l = t / 2 - 1;
        int h = t / 2 + 1;
        int q = t / 4;
        case (code)
            1: return y == h;
            2: return x == l;
            3: return y == l;
            4: return x == h;
            5: return (y == h && x > h + 1) || (x == h && y > h + 1) || (x == h + 1 && y == h + 1);
            6: return (y == h && x < l - 1) || (x == l && y > h + 1) || (x == l - 1 && y == h + 1);
            7: return (y == l && x < l - 1) || (x == l && y < l - 1) || (x == l - 1 && y == l - 1);
            0: return (y == l && x > h + 1) || (x == h && y < l - 1) || (x == h + 1 && y == l - 1);
            9: return (x == l || x == l + 1) && (y == l || y == l + 1);
            10: return (x >= q && x <= 3 * q - 1 && y >= 1 && y <= t - 2)
                    || (y >= q && y <= 3 * q - 1 && x >= 1 && x <= t - 2);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int scale_ch(int n, int w);
        return (((n << 4) | n) >> (8 - w)) & ((1 << w) - 1);
    endfunction

    function automatic int exp_pix(int k, int code, int x, int y);
        int w = width_n[k];
        int mx = (1 << w) - 1;
        bit blink_on = ((blink_pulses[k] / blink_n[k]) % 2) == 0;
        bit white = ((flash_pulses[k] / flash_n[k]) % 2) == 1;
        if (!geom(tile_n[k], code, x, y)) return 0;
        if (code <= 7) return white ? pack(0, mx, mx, mx, w) : pack(0, 0, 0, mx, w);
        if (code == 9 || blink_on) return pack(0, scale_ch(15, w), scale_ch(11, w), scale_ch(9, w), w);
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            blink_pulses[k] = 0;
            flash_pulses[k] = 0;
            exp_out[k]      = 0;
            fe_hold[k]      = 1'b0;
        end
    endtask

    // One clock: DUT k gets the given request, the other idles. Both outputs are
    // compared against the model's prediction for the request made one step earlier.
    task automatic step(int k, bit fs, bit fe, bit v, int code, int x, int y);
        bit fsv[2];
        bit fev[2];
        int nxt[2];
        fe_hold[k] = fe;
        for (int j = 0; j < 2; j++) begin
            fsv[j] = (j == k) ? fs : 1'b0;
            fev[j] = fe_hold[j];
            nxt[j] = (j == k && v) ? ((1 << 24) | exp_pix(j, code, x, y)) : 0;
        end
        if_a.frame_start = fsv[0];  if_a.flash_en = fev[0];
        if_a.in_valid    = (k == 0) && v;
        if_a.sprite_code = 4'(code); if_a.sx = 3'(x); if_a.sy = 3'(y);
        if_b.frame_start = fsv[1];  if_b.flash_en = fev[1];
        if_b.in_valid    = (k == 1) && v;
        if_b.sprite_code = 4'(code); if_b.sx = 4'(x); if_b.sy = 4'(y);
        @(posedge clk);
        for (int j = 0; j < 2; j++) begin
            if (fsv[j]) blink_pulses[j]++;
            if (!fev[j]) flash_pulses[j] = 0;
            else if (fsv[j]) flash_pulses[j]++;
        end
        #1;
        check("model_a", out_of(0), exp_out[0]);
        check("model_b", out_of(1), exp_out[1]);
        exp_out = nxt;
    endtask

    // One pixel on DUT A followed by an idle cycle; returns the pixel as it emerged.
    task automatic pix(bit fs, bit fe, int code, int x, int y, output int got);
        step(0, fs, fe, 1'b1, code, x, y);
        step(0, 1'b0, fe, 1'b0, 0, 0, 0);
        got = out_of(0);
    endtask

    task automatic sweep(int k, int code, output int lit);
        lit = 0;
        for (int y = 0; y < tile_n[k]; y++) begin
            for (int x = 0; x < tile_n[k]; x++) begin
                step(k, 1'b0, 1'b0, 1'b1, code, x, y);
                if ((out_of(k) & 24'hFFFFFF) != 0) lit++;
            end
        end
        step(k, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        if ((out_of(k) & 24'hFFFFFF) != 0) lit++;
    endtask

    localparam int V = 1 << 24;

    initial begin
        vec_t tbl[21];
        int got;
        int lit;
        int blink_exp[9];
        bit blink_fs[9];
        tbl = '{
            '{1, 0, 5, 'h00F}, '{1, 0, 4, 'h000}, '{2, 3, 0, 'h00F}, '{3, 7, 3, 'h00F},
            '{4, 5, 7, 'h00F}, '{5, 7, 5, 'h00F}, '{5, 6, 6, 'h00F}, '{5, 6, 5, 'h000},
            '{6, 0, 5, 'h00F}, '{7, 3, 0, 'h00F}, '{0, 7, 3, 'h00F}, '{0, 5, 0, 'h00F},
            '{0, 5, 2, 'h000}, '{9, 4, 3, 'hFB9}, '{9, 5, 3, 'h000}, '{10, 2, 1, 'hFB9},
            '{10, 1, 1, 'h000}, '{10, 6, 3, 'hFB9}, '{10, 7, 3, 'h000}, '{8, 3, 3, 'h000},
            '{15, 3, 5, 'h000}
        };
        blink_fs  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        blink_exp = '{'hFB9, 'hFB9, 'hFB9, 'hFB9, 'h000, 'h000, 'h000, 'h000, 'hFB9};

        if_a.frame_start = 0; if_a.flash_en = 0; if_a.in_valid = 0;
        if_a.sprite_code = 0; if_a.sx = 0; if_a.sy = 0;
        if_b.frame_start = 0; if_b.flash_en = 0; if_b.in_valid = 0;
        if_b.sprite_code = 0; if_b.sx = 0; if_b.sy = 0;
        model_reset();
        #3;
        check("reset_a", out_of(0), 0);
        check("reset_b", out_of(1), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table on DUT A, back to back; output i shows up one step after pixel i.
        for (int i = 0; i <= 21; i++) begin
            if (i < 21) step(0, 1'b0, 1'b0, 1'b1, tbl[i].code, tbl[i].x, tbl[i].y);
            else        step(0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            if (i > 0) check($sformatf("tbl%0d", i - 1), out_of(0), V | tbl[i - 1].rgb);
        end

        for (int c = 0; c < 16; c++) begin
            sweep(0, c, lit);
            if (c == 1) check("t8_code1_lit", lit, 8);
            if (c == 2) check("t8_code2_lit", lit, 8);
            if (c == 8) check("t8_code8_lit", lit, 0);
        end
        for (int c = 0; c < 16; c++) begin
            sweep(1, c, lit);
            if (c == 9) check("t16_code9_lit", lit, 4);
            if (c == 4) check("t16_code4_lit", lit, 16);
        end
        step(1, 1'b0, 1'b0, 1'b1, 9, 8, 8);
        step(1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("t16_pellet_6bit", out_of(1), V | pack(0, 'h3F, 'h2E, 'h26, 6));

        // Blink, two frames per phase; odd entries carry frame_start with the pixel.
        for (int i = 0; i < 9; i++) begin
            pix(blink_fs[i], 1'b0, 10, 4, 4, got);
            check($sformatf("blink%0d", i), got, V | blink_exp[i]);
        end

        // Wall flash, one frame per phase.
        step(0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        pix(1'b0, 1'b1, 1, 0, 5, got); check("flash0", got, V | 'h00F);
        pix(1'b1, 1'b1, 1, 0, 5, got); check("flash0_fs", got, V | 'h00F);
        pix(1'b0, 1'b1, 1, 0, 5, got); check("flash1", got, V | 'hFFF);
        pix(1'b1, 1'b1, 1, 0, 5, got); check("flash1_fs", got, V | 'hFFF);
        pix(1'b0, 1'b1, 1, 0, 5, got); check("flash2", got, V | 'h00F);
        pix(1'b1, 1'b1, 1, 0, 5, got); check("flash2_fs", got, V | 'h00F);
        step(0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        pix(1'b0, 1'b0, 1, 0, 5, got); check("flash_drop", got, V | 'h00F);
        step(0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        pix(1'b0, 1'b1, 1, 0, 5, got); check("flash_clear_wins", got, V | 'h00F);

        // Reset in the middle of a stream.
        step(0, 1'b0, 1'b0, 1'b1, 1, 0, 5);
        step(0, 1'b0, 1'b0, 1'b1, 1, 0, 5);
        #2 rst_n = 1'b0;
        #1 check("async_reset_a", out_of(0), 0);
        check("async_reset_b", out_of(1), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("no_out_on_release", out_of(0), 0);
        step(0, 1'b0, 1'b0, 1'b1, 1, 0, 5);
        check("lat_cycle1", out_of(0), 0);
        step(0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("lat_cycle2", out_of(0), V | 'h00F);

        // Back-to-back random traffic on both geometries.
        for (int k = 0; k < 2; k++) begin
            bit fe = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                if ($urandom_range(19) == 0) fe = ~fe;
                step(k, ($urandom_range(k == 0 ? 5 : 2) == 0), fe, 1'b1, $urandom_range(15),
                     $urandom_range(tile_n[k] - 1), $urandom_range(tile_n[k] - 1));
            end
            step(k, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
